// File: rtl/ysyx_22050598_trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Holds CSR addresses, mcause values, mstatus bit positions, the FSM state
// encoding and a helper for the direct-mode mtvec base.
package ysyx_22050598_trap_ctrl_pkg;

  localparam int XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] ECALL_M = 64'h0000_0000_0000_000b;
  localparam logic [XLEN-1:0] IRQ_MTI = 64'h8000_0000_0000_0007;

  localparam int MIE    = 3;
  localparam int MPIE   = 7;
  localparam int MPP_HI = 12;
  localparam int MPP_LO = 11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_MEPC    = 3'd1,
    S_W_MCAUSE  = 3'd2,
    S_W_MSTATUS = 3'd3,
    S_REDIRECT  = 3'd4
  } trap_state_e;

  // Only direct mode is supported: the low two mode bits are dropped.
  function automatic logic [XLEN-1:0] mtvec_base(input logic [XLEN-1:0] mtvec);
    return mtvec & ~64'h3;
  endfunction

endpackage

// File: rtl/ysyx_22050598_trap_mstatus_next.sv
// Computes the mstatus value written on trap entry or mret.
// Ports:
//   mstatus     - current mstatus
//   is_mret     - 1: mret update, 0: trap-entry update
//   mstatus_new - updated mstatus (all other bits pass through)
module ysyx_22050598_trap_mstatus_next
  import ysyx_22050598_trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] mstatus,
  input  logic            is_mret,
  output logic [XLEN-1:0] mstatus_new
);

  always_comb begin
    mstatus_new = mstatus;
    if (is_mret) begin
      mstatus_new[MIE]  = mstatus[MPIE];
      mstatus_new[MPIE] = 1'b1;
    end else begin
      mstatus_new[MPIE] = mstatus[MIE];
      mstatus_new[MIE]  = 1'b0;
    end
    mstatus_new[MPP_HI:MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/ysyx_22050598_trap_ctrl.sv
// Trap sequencer: accepts ecall / mret / timer interrupt from EX, stalls the
// pipeline, writes mepc, mcause, mstatus one per cycle, then redirects the IFU.
//
// state       | meaning
// S_IDLE      | waiting for an event; accepts irq > ecall > mret
// S_W_MEPC    | writing mepc (trap only)
// S_W_MCAUSE  | writing mcause (trap only)
// S_W_MSTATUS | writing mstatus
// S_REDIRECT  | holding redirect until the IFU accepts
//
// Ports:
//   clk, rst                           - clock, synchronous active-high reset
//   trap_ecall_i/trap_mret_i/irq_timer_i - events from EX / CLINT
//   trap_pc_i                          - PC of the EX instruction
//   csr_mstatus_i/mtvec_i/mepc_i       - current CSR values
//   csr_wen_o/waddr_o/wdata_o          - single CSR write port
//   pipe_stall_o                       - freeze IF/ID/EX
//   redirect_valid_o/pc_o, redirect_ready_i - IFU redirect handshake
module ysyx_22050598_trap_ctrl
  import ysyx_22050598_trap_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_ecall_i,
  input  logic            trap_mret_i,
  input  logic            irq_timer_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  output logic            csr_wen_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            pipe_stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i
);

  trap_state_e     state;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] target_q;
  logic            is_mret_q;

  logic            idle;
  logic            accept_irq;
  logic            accept_ecall;
  logic            accept_mret;
  logic            ms_is_mret;
  logic [XLEN-1:0] mstatus_new;

  assign idle         = (state == S_IDLE);
  assign accept_irq   = idle & irq_timer_i & csr_mstatus_i[MIE];
  assign accept_ecall = idle & trap_ecall_i & ~accept_irq;
  assign accept_mret  = idle & trap_mret_i & ~trap_ecall_i & ~accept_irq;

  // Combinational term freezes EX in the accept cycle itself.
  assign pipe_stall_o = ~idle | accept_irq | accept_ecall | accept_mret;

  // In IDLE the mstatus value is only consumed by an mret accept.
  assign ms_is_mret = idle | is_mret_q;

  ysyx_22050598_trap_mstatus_next u_mstatus_next (
    .mstatus     (csr_mstatus_i),
    .is_mret     (ms_is_mret),
    .mstatus_new (mstatus_new)
  );

  // Outputs are registered: each transition loads the outputs of the state
  // being entered. The mepc value (epc) lives in the write-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cause_q          <= '0;
      target_q         <= '0;
      is_mret_q        <= 1'b0;
      csr_wen_o        <= 1'b0;
      csr_waddr_o      <= '0;
      csr_wdata_o      <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      csr_wen_o   <= 1'b0;
      csr_waddr_o <= '0;
      csr_wdata_o <= '0;
      case (state)
        S_IDLE: begin
          if (accept_irq | accept_ecall) begin
            is_mret_q   <= 1'b0;
            cause_q     <= accept_irq ? IRQ_MTI : ECALL_M;
            state       <= S_W_MEPC;
            csr_wen_o   <= 1'b1;
            csr_waddr_o <= CSR_MEPC;
            csr_wdata_o <= trap_pc_i;
          end else if (accept_mret) begin
            is_mret_q   <= 1'b1;
            target_q    <= csr_mepc_i;
            state       <= S_W_MSTATUS;
            csr_wen_o   <= 1'b1;
            csr_waddr_o <= CSR_MSTATUS;
            csr_wdata_o <= mstatus_new;
          end
        end
        S_W_MEPC: begin
          state       <= S_W_MCAUSE;
          csr_wen_o   <= 1'b1;
          csr_waddr_o <= CSR_MCAUSE;
          csr_wdata_o <= cause_q;
        end
        S_W_MCAUSE: begin
          state       <= S_W_MSTATUS;
          csr_wen_o   <= 1'b1;
          csr_waddr_o <= CSR_MSTATUS;
          csr_wdata_o <= mstatus_new;
        end
        S_W_MSTATUS: begin
          state            <= S_REDIRECT;
          redirect_valid_o <= 1'b1;
          if (is_mret_q) begin
            redirect_pc_o <= target_q;
          end else begin
            target_q      <= mtvec_base(csr_mtvec_i);
            redirect_pc_o <= mtvec_base(csr_mtvec_i);
          end
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            state            <= S_IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_trap_ctrl.sv
module tb_ysyx_22050598_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_ecall_i, trap_mret_i, irq_timer_i;
  logic [63:0] trap_pc_i, csr_mstatus_i, csr_mtvec_i, csr_mepc_i;
  logic        csr_wen_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o;
  logic        pipe_stall_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_22050598_trap_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .trap_ecall_i     (trap_ecall_i),
    .trap_mret_i      (trap_mret_i),
    .irq_timer_i      (irq_timer_i),
    .trap_pc_i        (trap_pc_i),
    .csr_mstatus_i    (csr_mstatus_i),
    .csr_mtvec_i      (csr_mtvec_i),
    .csr_mepc_i       (csr_mepc_i),
    .csr_wen_o        (csr_wen_o),
    .csr_waddr_o      (csr_waddr_o),
    .csr_wdata_o      (csr_wdata_o),
    .pipe_stall_o     (pipe_stall_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: new mstatus from the architectural field rules.
  function automatic logic [63:0] ref_mstatus(input logic [63:0] ms, input bit mret);
    logic [63:0] m;
    m = ms;
    if (mret) begin
      m = (m & ~64'h8) | (((ms >> 7) & 64'h1) << 3);
      m = m | 64'h80;
    end else begin
      m = (m & ~64'h80) | (((ms >> 3) & 64'h1) << 7);
      m = m & ~64'h8;
    end
    return m | 64'h1800;
  endfunction

  // Drives one event in cycle 0, then checks every cycle until back in IDLE.
  task automatic run_event(input bit ecall, input bit mret, input bit irq,
                           input logic [63:0] pc, input logic [63:0] ms,
                           input logic [63:0] mtvec, input logic [63:0] mepc,
                           input int delay, input string name);
    bit is_irq, is_trap, is_mret, acc;
    logic [63:0] cause, target, ms_new;
    int rs, last;
    logic        e_wen, e_valid, e_stall;
    logic [11:0] e_addr;
    logic [63:0] e_data, e_pc;
    is_irq  = irq && ms[3];
    is_trap = is_irq || ecall;
    is_mret = !is_trap && mret;
    acc     = is_trap || is_mret;
    cause   = is_irq ? 64'h8000_0000_0000_0007 : 64'h0b;
    ms_new  = ref_mstatus(ms, is_mret);
    target  = is_trap ? ((mtvec >> 2) << 2) : mepc;
    rs      = is_trap ? 4 : 2;
    last    = rs + delay + 1;

    tick();
    trap_ecall_i = ecall; trap_mret_i = mret; irq_timer_i = irq;
    trap_pc_i = pc; csr_mstatus_i = ms; csr_mtvec_i = mtvec; csr_mepc_i = mepc;
    redirect_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (pipe_stall_o !== acc) begin
      failures++;
      $display("FAIL %s accept_stall got=%0b want=%0b", name, pipe_stall_o, acc);
    end
    checks++;
    if (csr_wen_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s accept_quiet got wen=%0b valid=%0b want 0/0", name, csr_wen_o, redirect_valid_o);
    end
    if (!acc) begin
      tick();
      trap_ecall_i = 0; trap_mret_i = 0; irq_timer_i = 0;
      return;
    end

    for (int k = 1; k <= last; k++) begin
      tick();
      trap_ecall_i = 0; trap_mret_i = 0; irq_timer_i = 0;
      redirect_ready_i = (k >= rs + delay);
      @(negedge clk);
      e_wen = 0; e_addr = '0; e_data = '0; e_valid = 0; e_pc = '0;
      e_stall = (k < last);
      if (is_trap && k == 1) begin e_wen = 1; e_addr = 12'h341; e_data = pc; end
      if (is_trap && k == 2) begin e_wen = 1; e_addr = 12'h342; e_data = cause; end
      if ((is_trap && k == 3) || (is_mret && k == 1)) begin
        e_wen = 1; e_addr = 12'h300; e_data = ms_new;
      end
      if (k >= rs && k < last) begin e_valid = 1; e_pc = target; end
      checks++;
      if (csr_wen_o !== e_wen) begin
        failures++;
        $display("FAIL %s c%0d wen got=%0b want=%0b", name, k, csr_wen_o, e_wen);
      end
      checks++;
      if (csr_waddr_o !== e_addr) begin
        failures++;
        $display("FAIL %s c%0d waddr got=%h want=%h", name, k, csr_waddr_o, e_addr);
      end
      checks++;
      if (csr_wdata_o !== e_data) begin
        failures++;
        $display("FAIL %s c%0d wdata got=%h want=%h", name, k, csr_wdata_o, e_data);
      end
      checks++;
      if (redirect_valid_o !== e_valid) begin
        failures++;
        $display("FAIL %s c%0d valid got=%0b want=%0b", name, k, redirect_valid_o, e_valid);
      end
      checks++;
      if (redirect_pc_o !== e_pc) begin
        failures++;
        $display("FAIL %s c%0d rpc got=%h want=%h", name, k, redirect_pc_o, e_pc);
      end
      checks++;
      if (pipe_stall_o !== e_stall) begin
        failures++;
        $display("FAIL %s c%0d stall got=%0b want=%0b", name, k, pipe_stall_o, e_stall);
      end
    end
    redirect_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1; trap_ecall_i = 0; trap_mret_i = 0; irq_timer_i = 0;
    trap_pc_i = '0; csr_mstatus_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0;
    redirect_ready_i = 0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({csr_wen_o, csr_waddr_o, csr_wdata_o, pipe_stall_o, redirect_valid_o, redirect_pc_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got wen=%0b addr=%h data=%h stall=%0b valid=%0b pc=%h want all 0",
               csr_wen_o, csr_waddr_o, csr_wdata_o, pipe_stall_o, redirect_valid_o, redirect_pc_o);
    end
    tick();
    rst = 0;
  endtask

  task automatic test_ecall();
    run_event(1, 0, 0, 64'h8000_0100, 64'h8, 64'h8000_0003, 64'h0, 0, "ecall");
  endtask

  task automatic test_mret();
    run_event(0, 1, 0, 64'h0, 64'h1880, 64'h0, 64'h8000_0104, 0, "mret");
  endtask

  task automatic test_irq_priority();
    run_event(1, 0, 1, 64'h8000_0200, 64'h8, 64'h8000_1000, 64'h0, 0, "irq_vs_ecall");
    run_event(1, 1, 0, 64'h8000_0300, 64'h8, 64'h8000_1000, 64'h8000_0400, 0, "ecall_vs_mret");
    csr_mstatus_i = 64'h1880;
    for (int i = 0; i < 3; i++) begin
      tick();
      irq_timer_i = 1;
      @(negedge clk);
      checks++;
      if (pipe_stall_o !== 1'b0 || csr_wen_o !== 1'b0) begin
        failures++;
        $display("FAIL irq_no_reentry got stall=%0b wen=%0b want 0/0", pipe_stall_o, csr_wen_o);
      end
    end
    tick();
    irq_timer_i = 0;
  endtask

  task automatic test_backpressure();
    run_event(1, 0, 0, 64'h8000_0500, 64'h0, 64'h8000_2001, 64'h0, 3, "bp_trap");
    run_event(0, 1, 0, 64'h0, 64'h80, 64'h0, 64'h8000_0600, 2, "bp_mret");
  endtask

  task automatic test_irq_masked();
    run_event(0, 0, 1, 64'h8000_0700, 64'h0, 64'h8000_3000, 64'h0, 0, "irq_masked");
    for (int i = 0; i < 2; i++) begin
      tick();
      irq_timer_i = 1; csr_mstatus_i = 64'h0;
      @(negedge clk);
      checks++;
      if (pipe_stall_o !== 1'b0) begin
        failures++;
        $display("FAIL irq_masked_hold stall got=%0b want=0", pipe_stall_o);
      end
    end
    tick();
    irq_timer_i = 0;
  endtask

  task automatic test_rst_mid();
    tick();
    trap_ecall_i = 1; trap_pc_i = 64'h8000_0800; csr_mstatus_i = 64'h8; csr_mtvec_i = 64'h8000_4000;
    tick();
    trap_ecall_i = 0;
    tick();
    rst = 1;
    @(negedge clk);
    checks++;
    if (csr_wen_o !== 1'b1 || csr_waddr_o !== 12'h342) begin
      failures++;
      $display("FAIL rst_mid_precond got wen=%0b addr=%h want 1/342", csr_wen_o, csr_waddr_o);
    end
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if ({csr_wen_o, csr_waddr_o, csr_wdata_o, pipe_stall_o, redirect_valid_o, redirect_pc_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got wen=%0b addr=%h data=%h stall=%0b valid=%0b want all 0",
               csr_wen_o, csr_waddr_o, csr_wdata_o, pipe_stall_o, redirect_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      redirect_ready_i = 1;
      @(negedge clk);
      checks++;
      if (csr_wen_o !== 1'b0 || redirect_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_quiet got wen=%0b valid=%0b want 0/0", csr_wen_o, redirect_valid_o);
      end
    end
    redirect_ready_i = 0;
    run_event(1, 0, 0, 64'h8000_0900, 64'h8, 64'h8000_5002, 64'h0, 1, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_irq_priority();
    test_backpressure();
    test_irq_masked();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22050598_trap_ctrl.md
# ysyx_22050598_trap_ctrl

Trap sequencer for the machine-mode CSR file. It accepts ecall, mret and machine-timer interrupt events from EX and freezes the pipeline while it runs. It then writes mepc, mcause and mstatus one per cycle through a single CSR write port and issues a PC redirect to the IFU with a valid/ready handshake. It sits between the EX stage, the CSR register file and the IFU, and owns all trap-side CSR updates.

## Interface
- XLEN, 64, CSR and PC width
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- trap_ecall_i  in  1  ecall in EX this cycle
- trap_mret_i  in  1  mret in EX this cycle
- irq_timer_i  in  1  MTIP level from CLINT
- trap_pc_i  in  XLEN  PC of the EX instruction; the interrupt also saves this PC
- csr_mstatus_i  in  XLEN  current mstatus
- csr_mtvec_i  in  XLEN  current mtvec
- csr_mepc_i  in  XLEN  current mepc
- csr_wen_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- pipe_stall_o  out  1  freeze IF/ID/EX
- redirect_valid_o  out  1  redirect request to IFU
- redirect_pc_o  out  XLEN  redirect target
- redirect_ready_i  in  1  IFU accepts redirect

## Operation
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
- Accept happens only in IDLE. Priority order:
  - irq: irq_timer_i & csr_mstatus_i[3]
  - ecall
  - mret
- Requests outside IDLE are ignored. EX holds them because stall is asserted.
- On a trap accept (irq or ecall):
  - Latch trap_pc_i as epc.
  - Latch cause: 64'h8000_0000_0000_0007 for irq, 64'h0b for ecall.
  - Go to W_MEPC.
- On an mret accept:
  - Latch csr_mepc_i as target.
  - Go to W_MSTATUS.
- W_MEPC: wen=1, addr=12'h341, wdata=epc. Next state W_MCAUSE.
- W_MCAUSE: wen=1, addr=12'h342, wdata=cause. Next state W_MSTATUS.
- W_MSTATUS: wen=1, addr=12'h300, wdata = csr_mstatus_i with these fields changed:
  - trap: MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - mret: MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11.
  - All other bits pass through unchanged.
  - On a trap, also latch target = {csr_mtvec_i[63:2], 2'b00} (direct mode only).
  - Next state REDIRECT.
- REDIRECT: redirect_valid_o=1 and redirect_pc_o=target, both held stable until redirect_ready_i=1. Next state IDLE.
- Outside the write states, csr_wen_o=0, csr_waddr_o=0 and csr_wdata_o=0.
- pipe_stall_o = (state!=IDLE) | accept_in_IDLE. The combinational term freezes EX in the accept cycle.

## Timing
- Reset values: state=IDLE and every output 0. Latched epc, cause and target are cleared to 0.
- Trap, with accept in cycle 0:
  - mepc write in cycle 1, mcause in cycle 2, mstatus in cycle 3.
  - redirect_valid from cycle 4.
  - If ready arrives in cycle 4, IDLE and stall=0 in cycle 5.
- mret, with accept in cycle 0: mstatus write in cycle 1, redirect_valid from cycle 2.
- Back-pressure: each cycle of redirect_ready_i=0 in REDIRECT adds one cycle. There is no timeout.
- Simultaneous events: irq beats ecall, and the ecall re-executes after the handler returns to the saved PC. ecall+mret together (illegal decode) takes ecall.
- irq_timer_i with MIE=0 is not accepted. An irq that rises mid-sequence is ignored until IDLE. After a trap MIE=0, so a held MTIP does not re-enter.
- CSR write and redirect never occur in the same cycle.
- rst mid-sequence: IDLE in the next cycle with all outputs 0. CSR writes already done are not undone. A pending redirect is dropped.

## Structure
- Shared defines file gets:
  - CSR addresses 12'h300, 12'h341, 12'h342.
  - Cause constants ECALL_M=64'h0b and IRQ_MTI=64'h8000_0000_0000_0007.
  - mstatus bit indices MIE=3, MPIE=7, MPP=12:11.
  - FSM state encodings (3 bits).
- One sub-module, ysyx_22050598_trap_mstatus_next: combinational, inputs mstatus and is_mret, output new mstatus.
- State and latch registers use the existing gnrl dfflr cells.

## Test plan
- ecall: trap_pc_i=64'h8000_0100, mtvec=64'h8000_0003, mstatus=64'h8 → required response:
  - cycle 1: 341 ← 64'h8000_0100.
  - cycle 2: 342 ← 64'h0b.
  - cycle 3: 300 ← 64'h1880.
  - cycle 4: redirect_pc=64'h8000_0000.
  - stall high in cycles 0–4.
- mret: mepc=64'h8000_0104, mstatus=64'h1880 → cycle 1: 300 ← 64'h1888; cycle 2: redirect 64'h8000_0104.
- irq_timer_i=1 with mstatus=64'h8, plus ecall in the same cycle → mcause ← 64'h8000_0000_0000_0007 and mepc ← ecall PC. Then, with MTIP still 1 and MIE=0, no second accept.
- Redirect back-pressure: ready=0 for 3 cycles → valid and pc stable throughout, IDLE one cycle after ready=1.
- rst asserted during W_MCAUSE → the next cycle has state IDLE, all outputs 0 and no mstatus write. A fresh ecall afterwards completes normally.
- irq_timer_i=1 with mstatus=0 → no accept, stall stays 0.
